// File: rtl/npu_ctrl_unit.sv
// ---------------------------------------------------------------------------
// npu_ctrl_unit
//
// Host-command decoder and dispatcher for the TinyNPU. The HPS writes 32-bit
// command words over the h2f bridge. Each word is decoded into one of four
// command types:
//   - LOAD/STORE between SDRAM and the register file
//   - register-file line MOVE
//   - EU instruction fetch
//   - EU execute
// Accepted commands produce a registered, single-cycle start pulse one cycle
// after the write strobe. Operands are latched at the same edge and held
// until the next accepted command on that channel.
//
// LDST and MOVE are tracked with busy flags. A command aimed at a busy
// channel is dropped, and cmd_drop pulses one cycle later. EU commands are
// never dropped.
//
// Ports:
//   clk, rst                    clock / asynchronous active-high reset
//   h2f_io, h2f_write           host command word and its write strobe
//   ldst_sdram_addr/rf_addr/line_num, load_start, store_start, ldst_done
//                               load/store engine interface
//   move_src_addr/dst_addr/mode/line_num, move_start, move_done
//                               move engine interface
//   eu_fetch, eu_exec           one-hot per-EU fetch / execute pulses
//   eu_fetch_addr               held fetch address
//   eu_busy                     per-EU busy levels
//   cmd_drop                    pulse for a rejected command
//   done                        whole-NPU idle indication
// ---------------------------------------------------------------------------
module npu_ctrl_unit #(
  parameter int RF_ADDR_W  = 10,
  parameter int LINE_NUM_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           h2f_io,
  input  logic                  h2f_write,
  output logic [31:0]           ldst_sdram_addr,
  output logic [RF_ADDR_W-1:0]  ldst_rf_addr,
  output logic [LINE_NUM_W-1:0] ldst_line_num,
  output logic                  load_start,
  output logic                  store_start,
  input  logic                  ldst_done,
  output logic [RF_ADDR_W-1:0]  move_src_addr,
  output logic [RF_ADDR_W-1:0]  move_dst_addr,
  output logic [1:0]            move_mode,
  output logic [LINE_NUM_W-1:0] move_line_num,
  output logic                  move_start,
  input  logic                  move_done,
  output logic [31:0]           eu_fetch,
  output logic [31:0]           eu_exec,
  output logic [31:0]           eu_fetch_addr,
  input  logic [31:0]           eu_busy,
  output logic                  cmd_drop,
  output logic                  done
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_EU    = 2'b11
  } op_e;

  function automatic logic [RF_ADDR_W-1:0] zext_rf9(input logic [8:0] v);
    return RF_ADDR_W'(v);
  endfunction

  function automatic logic [RF_ADDR_W-1:0] zext_rf10(input logic [9:0] v);
    return RF_ADDR_W'(v);
  endfunction

  function automatic logic [LINE_NUM_W-1:0] zext_lines(input logic [7:0] v);
    return LINE_NUM_W'(v);
  endfunction

  // Registered state
  logic [31:0]           ldst_sdram_addr_q, ldst_sdram_addr_d;
  logic [RF_ADDR_W-1:0]  ldst_rf_addr_q, ldst_rf_addr_d;
  logic [LINE_NUM_W-1:0] ldst_line_num_q, ldst_line_num_d;
  logic                  load_start_q, load_start_d;
  logic                  store_start_q, store_start_d;
  logic                  ldst_busy_q, ldst_busy_d;
  logic [RF_ADDR_W-1:0]  move_src_addr_q, move_src_addr_d;
  logic [RF_ADDR_W-1:0]  move_dst_addr_q, move_dst_addr_d;
  logic [1:0]            move_mode_q, move_mode_d;
  logic [LINE_NUM_W-1:0] move_line_num_q, move_line_num_d;
  logic                  move_start_q, move_start_d;
  logic                  move_busy_q, move_busy_d;
  logic [31:0]           eu_fetch_q, eu_fetch_d;
  logic [31:0]           eu_exec_q, eu_exec_d;
  logic [31:0]           eu_fetch_addr_q, eu_fetch_addr_d;
  logic                  cmd_drop_q, cmd_drop_d;

  // Decode
  op_e         op;
  logic        is_ldst, is_move, is_eu;
  logic        ldst_acc, move_acc;
  logic [31:0] eu_onehot;

  always_comb begin
    op        = op_e'(h2f_io[31:30]);
    is_ldst   = h2f_write && (op == OP_LOAD || op == OP_STORE);
    is_move   = h2f_write && (op == OP_MOVE);
    is_eu     = h2f_write && (op == OP_EU);
    // A done pulse in the same cycle frees the channel for a back-to-back issue.
    ldst_acc  = is_ldst && (!ldst_busy_q || ldst_done);
    move_acc  = is_move && (!move_busy_q || move_done);
    eu_onehot = 32'd1 << h2f_io[28:24];
  end

  always_comb begin
    ldst_sdram_addr_d = ldst_sdram_addr_q;
    ldst_rf_addr_d    = ldst_rf_addr_q;
    ldst_line_num_d   = ldst_line_num_q;
    load_start_d      = 1'b0;
    store_start_d     = 1'b0;
    ldst_busy_d       = ldst_busy_q;
    move_src_addr_d   = move_src_addr_q;
    move_dst_addr_d   = move_dst_addr_q;
    move_mode_d       = move_mode_q;
    move_line_num_d   = move_line_num_q;
    move_start_d      = 1'b0;
    move_busy_d       = move_busy_q;
    eu_fetch_d        = 32'd0;
    eu_exec_d         = 32'd0;
    eu_fetch_addr_d   = eu_fetch_addr_q;
    cmd_drop_d        = (is_ldst && !ldst_acc) || (is_move && !move_acc);

    if (ldst_done) ldst_busy_d = 1'b0;
    if (ldst_acc) begin
      ldst_rf_addr_d    = zext_rf9(h2f_io[29:21]);
      ldst_sdram_addr_d = {19'd0, h2f_io[20:8]};
      ldst_line_num_d   = zext_lines(h2f_io[7:0]);
      load_start_d      = (op == OP_LOAD);
      store_start_d     = (op == OP_STORE);
      ldst_busy_d       = 1'b1;
    end

    if (move_done) move_busy_d = 1'b0;
    if (move_acc) begin
      move_src_addr_d = zext_rf10(h2f_io[29:20]);
      move_dst_addr_d = zext_rf10(h2f_io[19:10]);
      move_mode_d     = h2f_io[9:8];
      move_line_num_d = zext_lines(h2f_io[7:0]);
      move_start_d    = 1'b1;
      move_busy_d     = 1'b1;
    end

    if (is_eu) begin
      if (h2f_io[29]) begin
        eu_exec_d = eu_onehot;
      end else begin
        eu_fetch_d      = eu_onehot;
        eu_fetch_addr_d = {8'd0, h2f_io[23:0]};
      end
    end
  end

  // Command register stage: pulses and held operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldst_sdram_addr_q <= '0;
      ldst_rf_addr_q    <= '0;
      ldst_line_num_q   <= '0;
      load_start_q      <= 1'b0;
      store_start_q     <= 1'b0;
      ldst_busy_q       <= 1'b0;
      move_src_addr_q   <= '0;
      move_dst_addr_q   <= '0;
      move_mode_q       <= '0;
      move_line_num_q   <= '0;
      move_start_q      <= 1'b0;
      move_busy_q       <= 1'b0;
      eu_fetch_q        <= '0;
      eu_exec_q         <= '0;
      eu_fetch_addr_q   <= '0;
      cmd_drop_q        <= 1'b0;
    end else begin
      ldst_sdram_addr_q <= ldst_sdram_addr_d;
      ldst_rf_addr_q    <= ldst_rf_addr_d;
      ldst_line_num_q   <= ldst_line_num_d;
      load_start_q      <= load_start_d;
      store_start_q     <= store_start_d;
      ldst_busy_q       <= ldst_busy_d;
      move_src_addr_q   <= move_src_addr_d;
      move_dst_addr_q   <= move_dst_addr_d;
      move_mode_q       <= move_mode_d;
      move_line_num_q   <= move_line_num_d;
      move_start_q      <= move_start_d;
      move_busy_q       <= move_busy_d;
      eu_fetch_q        <= eu_fetch_d;
      eu_exec_q         <= eu_exec_d;
      eu_fetch_addr_q   <= eu_fetch_addr_d;
      cmd_drop_q        <= cmd_drop_d;
    end
  end

  assign ldst_sdram_addr = ldst_sdram_addr_q;
  assign ldst_rf_addr    = ldst_rf_addr_q;
  assign ldst_line_num   = ldst_line_num_q;
  assign load_start      = load_start_q;
  assign store_start     = store_start_q;
  assign move_src_addr   = move_src_addr_q;
  assign move_dst_addr   = move_dst_addr_q;
  assign move_mode       = move_mode_q;
  assign move_line_num   = move_line_num_q;
  assign move_start      = move_start_q;
  assign eu_fetch        = eu_fetch_q;
  assign eu_exec         = eu_exec_q;
  assign eu_fetch_addr   = eu_fetch_addr_q;
  assign cmd_drop        = cmd_drop_q;
  // Idle only when both channels are free and no EU reports busy.
  assign done            = !ldst_busy_q && !move_busy_q && !(|eu_busy);

endmodule

// File: tb/tb_npu_ctrl_unit.sv
module tb_npu_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] h2f_io;
  logic        h2f_write;
  logic [31:0] ldst_sdram_addr;
  logic [9:0]  ldst_rf_addr;
  logic [7:0]  ldst_line_num;
  logic        load_start, store_start, ldst_done;
  logic [9:0]  move_src_addr, move_dst_addr;
  logic [1:0]  move_mode;
  logic [7:0]  move_line_num;
  logic        move_start, move_done;
  logic [31:0] eu_fetch, eu_exec, eu_fetch_addr, eu_busy;
  logic        cmd_drop, done;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  npu_ctrl_unit #(.RF_ADDR_W(10), .LINE_NUM_W(8)) dut (
    .clk(clk), .rst(rst), .h2f_io(h2f_io), .h2f_write(h2f_write),
    .ldst_sdram_addr(ldst_sdram_addr), .ldst_rf_addr(ldst_rf_addr),
    .ldst_line_num(ldst_line_num), .load_start(load_start),
    .store_start(store_start), .ldst_done(ldst_done),
    .move_src_addr(move_src_addr), .move_dst_addr(move_dst_addr),
    .move_mode(move_mode), .move_line_num(move_line_num),
    .move_start(move_start), .move_done(move_done),
    .eu_fetch(eu_fetch), .eu_exec(eu_exec), .eu_fetch_addr(eu_fetch_addr),
    .eu_busy(eu_busy), .cmd_drop(cmd_drop), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one write strobe; returns at the falling edge after the capturing edge.
  task automatic send(input logic [31:0] cmd);
    @(negedge clk);
    h2f_io    = cmd;
    h2f_write = 1'b1;
    @(negedge clk);
    h2f_write = 1'b0;
    h2f_io    = 32'd0;
  endtask

  task automatic pulse_ldst_done();
    @(negedge clk);
    ldst_done = 1'b1;
    @(negedge clk);
    ldst_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; h2f_io = 32'd0; h2f_write = 1'b0;
    ldst_done = 1'b0; move_done = 1'b0; eu_busy = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_load_start", 32'(load_start), 32'd0);
    chk("rst_sdram", ldst_sdram_addr, 32'd0);
    chk("rst_eu_addr", eu_fetch_addr, 32'd0);
    chk("rst_done", 32'(done), 32'd1);
    rst = 1'b0;

    // LOAD
    send({2'b00, 9'd0, 13'h1234, 8'd166});
    chk("load_start", 32'(load_start), 32'd1);
    chk("load_no_store", 32'(store_start), 32'd0);
    chk("load_rf", 32'(ldst_rf_addr), 32'd0);
    chk("load_sdram", ldst_sdram_addr, 32'h0000_1234);
    chk("load_lines", 32'(ldst_line_num), 32'd166);
    chk("load_done_low", 32'(done), 32'd0);
    @(negedge clk);
    chk("load_pulse_end", 32'(load_start), 32'd0);
    chk("load_busy_done", 32'(done), 32'd0);
    pulse_ldst_done();
    chk("load_finished_done", 32'(done), 32'd1);

    // STORE, then MOVE while LDST busy, then a dropped STORE
    send({2'b01, 9'd167, 13'h1abc, 8'd166});
    chk("store_start", 32'(store_start), 32'd1);
    chk("store_rf", 32'(ldst_rf_addr), 32'd167);
    chk("store_sdram", ldst_sdram_addr, 32'h0000_1ABC);
    chk("store_lines", 32'(ldst_line_num), 32'd166);
    send({2'b10, 10'd167, 10'h200, 2'b01, 8'd166});
    chk("move_start", 32'(move_start), 32'd1);
    chk("move_src", 32'(move_src_addr), 32'd167);
    chk("move_dst", 32'(move_dst_addr), 32'd512);
    chk("move_mode", 32'(move_mode), 32'd1);
    chk("move_lines", 32'(move_line_num), 32'd166);
    chk("move_no_drop", 32'(cmd_drop), 32'd0);
    send({2'b01, 9'd5, 13'h0001, 8'd2});
    chk("drop_pulse", 32'(cmd_drop), 32'd1);
    chk("drop_no_store", 32'(store_start), 32'd0);
    chk("drop_rf_hold", 32'(ldst_rf_addr), 32'd167);
    chk("drop_sdram_hold", ldst_sdram_addr, 32'h0000_1ABC);
    chk("drop_lines_hold", 32'(ldst_line_num), 32'd166);
    @(negedge clk);
    chk("drop_pulse_end", 32'(cmd_drop), 32'd0);

    // Back-to-back: ldst_done coincident with a new LOAD
    @(negedge clk);
    ldst_done = 1'b1; h2f_io = {2'b00, 9'd3, 13'h0042, 8'd7}; h2f_write = 1'b1;
    @(negedge clk);
    ldst_done = 1'b0; h2f_write = 1'b0; h2f_io = 32'd0;
    chk("b2b_load_start", 32'(load_start), 32'd1);
    chk("b2b_no_drop", 32'(cmd_drop), 32'd0);
    chk("b2b_done_low", 32'(done), 32'd0);
    chk("b2b_rf", 32'(ldst_rf_addr), 32'd3);
    chk("b2b_sdram", ldst_sdram_addr, 32'h0000_0042);
    pulse_ldst_done();

    // Second MOVE while move busy is dropped
    send({2'b10, 10'd1, 10'd2, 2'b10, 8'd9});
    chk("move_drop", 32'(cmd_drop), 32'd1);
    chk("move_drop_src_hold", 32'(move_src_addr), 32'd167);
    chk("move_drop_no_start", 32'(move_start), 32'd0);

    // FETCH / EXEC
    send({2'b11, 1'b0, 5'd17, 24'h345678});
    chk("fetch_onehot", eu_fetch, 32'h0002_0000);
    chk("fetch_addr", eu_fetch_addr, 32'h0034_5678);
    chk("fetch_no_exec", eu_exec, 32'd0);
    @(negedge clk);
    chk("fetch_pulse_end", eu_fetch, 32'd0);
    send({2'b11, 1'b1, 5'd17, 24'hxxxxxx});
    chk("exec_onehot", eu_exec, 32'h0002_0000);
    chk("exec_addr_hold", eu_fetch_addr, 32'h0034_5678);
    chk("exec_no_fetch", eu_fetch, 32'd0);
    send({2'b11, 1'b0, 5'd31, 24'h000001});
    chk("fetch_eu31", eu_fetch, 32'h8000_0000);

    // Reset while the move is still in flight
    chk("pre_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_move_src", 32'(move_src_addr), 32'd0);
    chk("arst_mode", 32'(move_mode), 32'd0);
    chk("arst_eu_addr", eu_fetch_addr, 32'd0);
    chk("arst_sdram", ldst_sdram_addr, 32'd0);
    chk("arst_done", 32'(done), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send({2'b10, 10'd1, 10'd2, 2'b11, 8'd4});
    chk("post_rst_move", 32'(move_start), 32'd1);
    chk("post_rst_mode", 32'(move_mode), 32'd3);
    chk("post_rst_no_drop", 32'(cmd_drop), 32'd0);

    // Stray ldst_done while LDST idle is ignored; eu_busy holds done low
    pulse_ldst_done();
    @(negedge clk);
    move_done = 1'b1;
    @(negedge clk);
    move_done = 1'b0;
    chk("idle_done", 32'(done), 32'd1);
    eu_busy = 32'h0000_0100;
    #1;
    chk("eu_busy_done", 32'(done), 32'd0);
    eu_busy = 32'd0;
    #1;
    chk("eu_idle_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/npu_ctrl_unit.md
Name: npu_ctrl_unit

Overview:
- Host-command decoder and dispatcher for the TinyNPU.
- Decodes 32-bit words written by the HPS over the h2f bridge into four command types:
  - SDRAM<->register-file load/store
  - register-file line move
  - execution-unit (EU) instruction fetch
  - EU execute
- Issues single-cycle start pulses with held operands to the LDST, MOVE and EU blocks.
- Tracks outstanding work and reports global idle on `done`.
- The rf_ldst and rf_move interface bundles are flattened into the ports below.

Parameters:
- RF_ADDR_W, 10: register-file address width; must be >= 10.
- LINE_NUM_W, 8: line-count width; must be >= 8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- h2f_io  in  32  host command word.
- h2f_write  in  1  one-cycle strobe; h2f_io is valid in that cycle.
- ldst_sdram_addr  out  32  SDRAM line address for load/store.
- ldst_rf_addr  out  RF_ADDR_W  register-file start address for load/store.
- ldst_line_num  out  LINE_NUM_W  number of lines to load/store.
- load_start  out  1  one-cycle load start pulse.
- store_start  out  1  one-cycle store start pulse.
- ldst_done  in  1  one-cycle pulse from the LDST engine when its operation finishes.
- move_src_addr  out  RF_ADDR_W  move source address.
- move_dst_addr  out  RF_ADDR_W  move destination address.
- move_mode  out  2  move mode field, passed through unchanged.
- move_line_num  out  LINE_NUM_W  number of lines to move.
- move_start  out  1  one-cycle move start pulse.
- move_done  in  1  one-cycle pulse from the MOVE engine when its operation finishes.
- eu_fetch  out  32  one-hot fetch pulse, one bit per EU.
- eu_exec  out  32  one-hot execute pulse, one bit per EU.
- eu_fetch_addr  out  32  fetch address.
- eu_busy  in  32  per-EU busy level.
- cmd_drop  out  1  one-cycle pulse when a command is rejected.
- done  out  1  high when the whole NPU is idle.

Behaviour:
- Opcode is h2f_io[31:30].
- 00 = LOAD, 01 = STORE; fields are:
  - rf address [29:21], 9 bits, zero-extended to RF_ADDR_W.
  - SDRAM address [20:8], 13 bits, zero-extended to 32.
  - line count [7:0], zero-extended to LINE_NUM_W.
- 10 = MOVE; fields are:
  - src [29:20], zero-extended to RF_ADDR_W.
  - dst [19:10], zero-extended to RF_ADDR_W.
  - mode [9:8].
  - line count [7:0].
- 11 = EU command; fields are:
  - [29] selects fetch (0) or exec (1).
  - EU index [28:24].
  - fetch address [23:0], zero-extended to 32; ignored for exec and may be X.
- Latency: a command on the h2f_write cycle produces its start pulse in the next cycle (registered at that edge).
- Operand outputs update at the same edge as the start pulse, then hold until the next accepted command of the same channel.
- Fetch: eu_fetch = 1 << index for one cycle; eu_fetch_addr updates at the same edge and holds.
- Exec: eu_exec = 1 << index for one cycle; eu_fetch_addr is unchanged.
- Busy tracking:
  - ldst_busy sets on an accepted LOAD/STORE and clears on ldst_done.
  - move_busy sets on an accepted MOVE and clears on move_done.
  - LDST and MOVE operate concurrently and independently.
- Rejection:
  - A LOAD/STORE while ldst_busy is dropped; a MOVE while move_busy is dropped.
  - On a drop, cmd_drop pulses in the next cycle and no output or state changes.
  - EU commands are never dropped.
- Simultaneous done + write on the same channel: the command is accepted and busy remains set (back-to-back issue allowed).
- A done pulse while the channel is not busy is ignored.
- `done` = ~ldst_busy & ~move_busy & ~|eu_busy, taken combinationally from registers and the input. It goes low in the same cycle as the accepted start pulse.
- h2f_write low: no action; h2f_io is don't-care.
- Reset (asynchronous, any time including mid-operation):
  - All outputs and registers go to 0 and busy flags clear.
  - `done` = 1 provided eu_busy = 0.
  - Engines in flight are not notified.

Test Plan:
- LOAD: write {00, 9'd0, 13'h1234, 8'd166} -> next cycle load_start = 1 for one cycle, ldst_rf_addr = 0, ldst_sdram_addr = 0x00001234, ldst_line_num = 166, done = 0. Pulse ldst_done -> done = 1.
- STORE: write {01, 9'd167, 13'h1abc, 8'd166} -> store_start pulse, ldst_rf_addr = 167, ldst_sdram_addr = 0x1ABC, ldst_line_num = 166. A second STORE before ldst_done -> cmd_drop pulse, outputs unchanged.
- MOVE: write {10, 10'd167, 10'h200, 2'b01, 8'd166} -> move_start pulse, src = 167, dst = 512, mode = 1, lines = 166. Issued while LDST is busy -> still accepted.
- FETCH: write {11, 0, 5'd17, 24'h345678} -> eu_fetch = 0x00020000 for one cycle, eu_fetch_addr = 0x00345678. EXEC: {11, 1, 5'd17, X} -> eu_exec = 0x00020000 for one cycle, eu_fetch_addr unchanged.
- Back-to-back: ldst_done coincident with a new LOAD write -> load accepted, no cmd_drop, done stays 0.
- Reset mid-move: assert rst with move_busy set -> all outputs 0 immediately, done = 1; a subsequent MOVE is accepted.
